// File: rtl/bp_update_sched_pkg.sv
// rtl/bp_update_sched_pkg.sv - shared types and widths for the branch-predictor update scheduler
`ifndef OBQ_SIZE
`define OBQ_SIZE 16
`endif

package bp_update_sched_pkg;

    localparam int OBQ_IDX_W    = $clog2(`OBQ_SIZE) + 1;
    localparam int UQ_DEPTH_DEF = 4;
    localparam int UQ_IDX_W     = $clog2(UQ_DEPTH_DEF);

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          target;
        logic                 taken;
        logic                 cond;
        logic                 direct;
        logic                 ret;
        logic                 correct;
        logic [OBQ_IDX_W-1:0] index;
    } BP_UPD_T;

    typedef enum logic [1:0] {
        BP_IDLE    = 2'd0,
        BP_RECOVER = 2'd1,
        BP_DONE    = 2'd2
    } BP_SCHED_STATE_T;

    function automatic BP_UPD_T bp_pack_upd(
        input logic [31:0]          pc,
        input logic [31:0]          target,
        input logic                 taken,
        input logic                 cond,
        input logic                 direct,
        input logic                 ret,
        input logic                 correct,
        input logic [OBQ_IDX_W-1:0] index
    );
        BP_UPD_T u;
        u.pc      = pc;
        u.target  = target;
        u.taken   = taken;
        u.cond    = cond;
        u.direct  = direct;
        u.ret     = ret;
        u.correct = correct;
        u.index   = index;
        return u;
    endfunction

endpackage

// File: rtl/bp_update_sched_fifo.sv
// rtl/bp_update_sched_fifo.sv - bp_upd_fifo: power-of-2 FIFO of retire updates with wrap-bit full/empty
module bp_upd_fifo
    import bp_update_sched_pkg::*;
#(
    parameter int DEPTH = UQ_DEPTH_DEF,
    parameter int PW    = UQ_IDX_W
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  BP_UPD_T push_data,
    input  logic    pop,
    output BP_UPD_T head,
    output logic    full,
    output logic    empty,
    output logic    one_left
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_wrap;
    logic          rd_wrap;
    logic [PW:0]   occ;
    BP_UPD_T       mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            wr_wrap <= 1'b0;
            rd_ptr  <= '0;
            rd_wrap <= 1'b0;
        end else begin
            if (push) {wr_wrap, wr_ptr} <= {wr_wrap, wr_ptr} + (PW+1)'(1);
            if (pop)  {rd_wrap, rd_ptr} <= {rd_wrap, rd_ptr} + (PW+1)'(1);
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head     = mem[rd_ptr];
    assign empty    = (wr_ptr == rd_ptr) && (wr_wrap == rd_wrap);
    assign full     = (wr_ptr == rd_ptr) && (wr_wrap != rd_wrap);
    assign occ      = {wr_wrap, wr_ptr} - {rd_wrap, rd_ptr};
    assign one_left = (occ == (PW+1)'(1));

endmodule

// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - retire-update scheduler for the predictor table port; UPD_BYPASS_EN enables same-cycle bypass writes
module bp_update_sched
    import bp_update_sched_pkg::*;
#(
    parameter int UQ_DEPTH     = UQ_DEPTH_DEF,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 if_en_branch,
    output logic                 if_stall,
    input  logic                 rt_en_branch,
    output logic                 rt_ready,
    input  logic                 rt_cond_branch,
    input  logic                 rt_direct_branch,
    input  logic                 rt_return_branch,
    input  logic                 rt_branch_taken,
    input  logic                 rt_prediction_correct,
    input  logic [31:0]          rt_pc,
    input  logic [31:0]          rt_calculated_pc,
    input  logic [OBQ_IDX_W-1:0] rt_branch_index,
    output logic                 tbl_wr_en,
    output BP_UPD_T              tbl_wr_upd,
    output logic                 recover_done,
    output logic [OBQ_IDX_W-1:0] recover_index
);

    localparam logic [1:0] ST_IDLE    = 2'(BP_IDLE);
    localparam logic [1:0] ST_RECOVER = 2'(BP_RECOVER);
    localparam logic [1:0] ST_DONE    = 2'(BP_DONE);
    localparam int         SC_W       = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    logic [1:0]           state;
    logic [SC_W-1:0]      starve_cnt;
    logic [OBQ_IDX_W-1:0] rec_idx;
    BP_UPD_T              rt_upd;
    BP_UPD_T              head;
    logic                 full;
    logic                 empty;
    logic                 one_left;
    logic                 accept;
    logic                 force_drain;
    logic                 drain;
    logic                 bypass;
    logic                 push;

    assign rt_upd = bp_pack_upd(rt_pc, rt_calculated_pc, rt_branch_taken, rt_cond_branch,
                                rt_direct_branch, rt_return_branch, rt_prediction_correct,
                                rt_branch_index);

    assign rt_ready    = !full && (state == ST_IDLE);
    assign accept      = rt_en_branch && rt_ready;
    assign force_drain = (starve_cnt == STARVE_MAX);

`ifdef UPD_BYPASS_EN
    // accept already implies IDLE
    assign bypass = accept && empty && !if_en_branch;
`else
    assign bypass = 1'b0;
`endif

    assign drain = !empty && ((state == ST_RECOVER) ||
                              ((state == ST_IDLE) && (!if_en_branch || force_drain)));
    assign push  = accept && !bypass;

    assign tbl_wr_en     = drain || bypass;
    assign tbl_wr_upd    = bypass ? rt_upd : (drain ? head : '0);
    assign if_stall      = force_drain || (state != ST_IDLE);
    assign recover_done  = (state == ST_DONE);
    assign recover_index = recover_done ? rec_idx : '0;

    bp_upd_fifo #(
        .DEPTH (UQ_DEPTH),
        .PW    ($clog2(UQ_DEPTH))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (rt_upd),
        .pop       (drain),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .one_left  (one_left)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (empty || drain) begin
            starve_cnt <= '0;
        end else if (!force_drain) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            rec_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && !rt_prediction_correct) begin
                        rec_idx <= rt_branch_index;
                        state   <= bypass ? ST_DONE : ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (drain && one_left) state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// tb/tb_bp_update_sched.sv - scoreboard bench for bp_update_sched
module tb_bp_update_sched;
    import bp_update_sched_pkg::*;

    localparam int STARVE = 8;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 if_en_branch = 1'b0;
    logic                 if_stall;
    logic                 rt_en_branch = 1'b0;
    logic                 rt_ready;
    logic                 rt_cond_branch = 1'b0;
    logic                 rt_direct_branch = 1'b0;
    logic                 rt_return_branch = 1'b0;
    logic                 rt_branch_taken = 1'b0;
    logic                 rt_prediction_correct = 1'b1;
    logic [31:0]          rt_pc = '0;
    logic [31:0]          rt_calculated_pc = '0;
    logic [OBQ_IDX_W-1:0] rt_branch_index = '0;
    logic                 tbl_wr_en;
    BP_UPD_T              tbl_wr_upd;
    logic                 recover_done;
    logic [OBQ_IDX_W-1:0] recover_index;

    int      checks = 0;
    int      failures = 0;
    BP_UPD_T exp_q[$];
    BP_UPD_T cur_upd;

    bp_update_sched #(.UQ_DEPTH(4), .STARVE_LIMIT(STARVE)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .if_en_branch          (if_en_branch),
        .if_stall              (if_stall),
        .rt_en_branch          (rt_en_branch),
        .rt_ready              (rt_ready),
        .rt_cond_branch        (rt_cond_branch),
        .rt_direct_branch      (rt_direct_branch),
        .rt_return_branch      (rt_return_branch),
        .rt_branch_taken       (rt_branch_taken),
        .rt_prediction_correct (rt_prediction_correct),
        .rt_pc                 (rt_pc),
        .rt_calculated_pc      (rt_calculated_pc),
        .rt_branch_index       (rt_branch_index),
        .tbl_wr_en             (tbl_wr_en),
        .tbl_wr_upd            (tbl_wr_upd),
        .recover_done          (recover_done),
        .recover_index         (recover_index)
    );

    always #5 clock = ~clock;

    function automatic BP_UPD_T mk_upd(input logic [31:0] pc, input logic correct,
                                       input logic [OBQ_IDX_W-1:0] idx);
        BP_UPD_T u;
        u.pc      = pc;
        u.target  = pc + 32'h1000;
        u.taken   = pc[2];
        u.cond    = ~pc[3];
        u.direct  = pc[3];
        u.ret     = pc[4];
        u.correct = correct;
        u.index   = idx;
        return u;
    endfunction

    task automatic drive_upd(input logic [31:0] pc, input logic correct,
                             input logic [OBQ_IDX_W-1:0] idx);
        cur_upd               = mk_upd(pc, correct, idx);
        rt_en_branch          = 1'b1;
        rt_pc                 = cur_upd.pc;
        rt_calculated_pc      = cur_upd.target;
        rt_branch_taken       = cur_upd.taken;
        rt_cond_branch        = cur_upd.cond;
        rt_direct_branch      = cur_upd.direct;
        rt_return_branch      = cur_upd.ret;
        rt_prediction_correct = cur_upd.correct;
        rt_branch_index       = cur_upd.index;
    endtask

    task automatic idle_upd();
        rt_en_branch = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    // Scoreboard: accepted updates in, table writes out, strictly in order.
    always @(negedge clock) begin
        if (reset) begin
            if (rt_en_branch && rt_ready) exp_q.push_back(cur_upd);
            if (tbl_wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_write got pc=%h required no write", tbl_wr_upd.pc);
                end else begin
                    BP_UPD_T e;
                    e = exp_q.pop_front();
                    if (tbl_wr_upd !== e) begin
                        failures++;
                        $display("FAIL sb_write_data got %h required %h", tbl_wr_upd, e);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        int wr;
        int dn;
        reset = 1'b0;
        idle_upd();
        if_en_branch = 1'b0;
        repeat (2) next_cycle();
        mid();
        checks++; if (rt_ready !== 1'b1)     begin failures++; $display("FAIL rst_rt_ready got %b required 1", rt_ready); end
        checks++; if (tbl_wr_en !== 1'b0)    begin failures++; $display("FAIL rst_wr_en got %b required 0", tbl_wr_en); end
        checks++; if (if_stall !== 1'b0)     begin failures++; $display("FAIL rst_if_stall got %b required 0", if_stall); end
        checks++; if (recover_done !== 1'b0) begin failures++; $display("FAIL rst_done got %b required 0", recover_done); end
        checks++; if (recover_index !== '0)  begin failures++; $display("FAIL rst_index got %0d required 0", recover_index); end
        checks++; if (tbl_wr_upd !== '0)     begin failures++; $display("FAIL rst_wr_upd got %h required 0", tbl_wr_upd); end
        next_cycle();
        reset = 1'b1;
        if_en_branch = 1'b1;
        drive_upd(32'h600, 1'b1, 5'd1);
        next_cycle();
        drive_upd(32'h604, 1'b0, 5'd2);
        next_cycle();
        idle_upd();
        reset = 1'b0;
        exp_q.delete();
        mid();
        checks++; if (rt_ready !== 1'b1)  begin failures++; $display("FAIL midrst_rt_ready got %b required 1", rt_ready); end
        checks++; if (tbl_wr_en !== 1'b0) begin failures++; $display("FAIL midrst_wr_en got %b required 0", tbl_wr_en); end
        checks++; if (if_stall !== 1'b0)  begin failures++; $display("FAIL midrst_if_stall got %b required 0", if_stall); end
        checks++; if (recover_done !== 1'b0) begin failures++; $display("FAIL midrst_done got %b required 0", recover_done); end
        next_cycle();
        reset = 1'b1;
        if_en_branch = 1'b0;
        wr = 0;
        dn = 0;
        repeat (10) begin
            mid();
            if (tbl_wr_en) wr++;
            if (recover_done) dn++;
            next_cycle();
        end
        checks++; if (wr != 0) begin failures++; $display("FAIL postrst_writes got %0d required 0", wr); end
        checks++; if (dn != 0) begin failures++; $display("FAIL postrst_done got %0d required 0", dn); end
    endtask

    task automatic test_fifo_order();
        int off;
`ifdef UPD_BYPASS_EN
        off = 0;
`else
        off = 1;
`endif
        if_en_branch = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) drive_upd(32'h100 + 32'(4 * c), 1'b1, 5'(c));
            else idle_upd();
            mid();
            checks++;
            if (tbl_wr_en !== ((c >= off) && (c < off + 4))) begin
                failures++;
                $display("FAIL order_wr_en c=%0d got %b required %b", c, tbl_wr_en, (c >= off) && (c < off + 4));
            end
            if ((c >= off) && (c < off + 4)) begin
                checks++;
                if (tbl_wr_upd.pc !== 32'h100 + 32'(4 * (c - off))) begin
                    failures++;
                    $display("FAIL order_pc c=%0d got %h required %h", c, tbl_wr_upd.pc, 32'h100 + 32'(4 * (c - off)));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_starve();
        logic e;
        if_en_branch = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c == 0) drive_upd(32'h300, 1'b1, 5'd7);
            else idle_upd();
            mid();
            e = (c == STARVE + 1);
            checks++; if (tbl_wr_en !== e) begin failures++; $display("FAIL starve_wr_en c=%0d got %b required %b", c, tbl_wr_en, e); end
            checks++; if (if_stall !== e)  begin failures++; $display("FAIL starve_if_stall c=%0d got %b required %b", c, if_stall, e); end
            next_cycle();
        end
    endtask

    task automatic test_full();
        logic er;
        logic ew;
        if_en_branch = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c < 4) drive_upd(32'h400 + 32'(4 * c), 1'b1, 5'(c + 8));
            else drive_upd(32'h410, 1'b1, 5'd12);
            mid();
            er = (c < 4) || (c == 10);
            ew = (c == 9);
            checks++; if (rt_ready !== er)  begin failures++; $display("FAIL full_rt_ready c=%0d got %b required %b", c, rt_ready, er); end
            checks++; if (tbl_wr_en !== ew) begin failures++; $display("FAIL full_wr_en c=%0d got %b required %b", c, tbl_wr_en, ew); end
            next_cycle();
        end
        idle_upd();
        if_en_branch = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) next_cycle();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_drain got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_recover();
        logic                 er, es, ew, ed;
        logic [OBQ_IDX_W-1:0] ei;
        if_en_branch = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) drive_upd(32'h500, 1'b1, 5'd1);
            else if (c == 1) drive_upd(32'h504, 1'b1, 5'd2);
            else if (c == 2) drive_upd(32'h508, 1'b0, 5'd5);
            else idle_upd();
            mid();
            er = (c <= 2) || (c >= 7);
            es = (c >= 3) && (c <= 6);
            ew = (c >= 3) && (c <= 5);
            ed = (c == 6);
            ei = ed ? 5'd5 : 5'd0;
            checks++; if (rt_ready !== er)     begin failures++; $display("FAIL rec_rt_ready c=%0d got %b required %b", c, rt_ready, er); end
            checks++; if (if_stall !== es)     begin failures++; $display("FAIL rec_if_stall c=%0d got %b required %b", c, if_stall, es); end
            checks++; if (tbl_wr_en !== ew)    begin failures++; $display("FAIL rec_wr_en c=%0d got %b required %b", c, tbl_wr_en, ew); end
            checks++; if (recover_done !== ed) begin failures++; $display("FAIL rec_done c=%0d got %b required %b", c, recover_done, ed); end
            checks++; if (recover_index !== ei) begin failures++; $display("FAIL rec_index c=%0d got %0d required %0d", c, recover_index, ei); end
            next_cycle();
        end
    endtask

`ifdef UPD_BYPASS_EN
    task automatic test_bypass();
        logic ew, ed;
        if_en_branch = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive_upd(32'h200, 1'b1, 5'd0);
            else if (c == 2) drive_upd(32'h208, 1'b0, 5'd3);
            else idle_upd();
            mid();
            ew = (c == 0) || (c == 2);
            ed = (c == 3);
            checks++; if (tbl_wr_en !== ew)    begin failures++; $display("FAIL byp_wr_en c=%0d got %b required %b", c, tbl_wr_en, ew); end
            checks++; if (recover_done !== ed) begin failures++; $display("FAIL byp_done c=%0d got %b required %b", c, recover_done, ed); end
            checks++; if (if_stall !== ed)     begin failures++; $display("FAIL byp_if_stall c=%0d got %b required %b", c, if_stall, ed); end
            if (ed) begin
                checks++; if (recover_index !== 5'd3) begin failures++; $display("FAIL byp_index got %0d required 3", recover_index); end
            end
            if (ew) begin
                checks++;
                if (tbl_wr_upd.pc !== ((c == 0) ? 32'h200 : 32'h208)) begin
                    failures++;
                    $display("FAIL byp_pc c=%0d got %h required %h", c, tbl_wr_upd.pc, (c == 0) ? 32'h200 : 32'h208);
                end
            end
            next_cycle();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fifo_order();
        test_starve();
        test_full();
        test_recover();
`ifdef UPD_BYPASS_EN
        test_bypass();
`endif
        repeat (2) next_cycle();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL final_pending got %0d required 0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
